// File: rtl/soc_pkg.sv
// Shared constants for the SoC: RV32I opcodes, UART register map, UART state type and the boot ROM image.
package soc_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [31:0] UART_TXDATA = 32'h1000_0000;
  localparam logic [31:0] UART_STATUS = 32'h1000_0004;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_e;

  // Boot program: print "Hi", polling STATUS between bytes, then spin on a self-jump.
  function automatic logic [31:0] rom_word(input int unsigned idx);
    case (idx)
      0:       rom_word = 32'h1000_00B7;  // lui  x1, 0x10000
      1:       rom_word = 32'h0480_0113;  // addi x2, x0, 0x48
      2:       rom_word = 32'h0020_A023;  // sw   x2, 0(x1)
      3:       rom_word = 32'h0040_A183;  // lw   x3, 4(x1)
      4:       rom_word = 32'hFE01_9EE3;  // bne  x3, x0, -4
      5:       rom_word = 32'h0690_0113;  // addi x2, x0, 0x69
      6:       rom_word = 32'h0020_A023;  // sw   x2, 0(x1)
      7:       rom_word = 32'h0040_A183;  // lw   x3, 4(x1)
      8:       rom_word = 32'hFE01_9EE3;  // bne  x3, x0, -4
      9:       rom_word = 32'h0000_006F;  // jal  x0, 0
      default: rom_word = NOP_INSTR;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; start bit is driven on the same edge that accepts start while idle.
module uart_tx
  import soc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       ser_out
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          ser_q;
  logic          last_c;

  assign last_c  = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign busy    = (state_q != UART_IDLE);
  assign ser_out = ser_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ser_q   <= 1'b1;
    end else begin
      case (state_q)
        UART_IDLE: begin
          if (start) begin
            state_q <= UART_START;
            shift_q <= data;
            cnt_q   <= '0;
            ser_q   <= 1'b0;
          end
        end
        UART_START: begin
          if (last_c) begin
            state_q <= UART_DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            ser_q   <= shift_q[0];
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        UART_DATA: begin
          if (last_c) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= UART_STOP;
              ser_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              ser_q   <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        UART_STOP: begin
          if (last_c) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= UART_IDLE;
          ser_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/soc_riscv_uart.sv
// Minimal SoC top: single-cycle RV32I-subset core running from a fixed ROM, with a memory-mapped UART TX.
module soc_riscv_uart
  import soc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned ROM_WORDS    = 32
) (
  input  logic clk,
  input  logic reset,
  output logic ser_out
);
  localparam int unsigned AW = $clog2(ROM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];
  logic [31:0] instr_c;
  logic [6:0]  opcode_c;
  logic [4:0]  rd_c, rs1_c, rs2_c;
  logic [2:0]  funct3_c;
  logic [31:0] imm_i_c, imm_s_c, imm_b_c, imm_u_c, imm_j_c;
  logic [31:0] rs1_val_c, rs2_val_c, ld_addr_c, st_addr_c, ld_data_c, wr_data_c;
  logic        wr_en_c, st_en_c, tx_start_c, tx_busy;

  assign instr_c  = rom_word(32'(pc_q[AW+1:2]));
  assign opcode_c = instr_c[6:0];
  assign rd_c     = instr_c[11:7];
  assign funct3_c = instr_c[14:12];
  assign rs1_c    = instr_c[19:15];
  assign rs2_c    = instr_c[24:20];

  assign imm_i_c = {{20{instr_c[31]}}, instr_c[31:20]};
  assign imm_s_c = {{20{instr_c[31]}}, instr_c[31:25], instr_c[11:7]};
  assign imm_b_c = {{19{instr_c[31]}}, instr_c[31], instr_c[7], instr_c[30:25], instr_c[11:8], 1'b0};
  assign imm_u_c = {instr_c[31:12], 12'b0};
  assign imm_j_c = {{11{instr_c[31]}}, instr_c[31], instr_c[19:12], instr_c[20], instr_c[30:21], 1'b0};

  assign rs1_val_c = (rs1_c == 5'd0) ? 32'd0 : rf_q[rs1_c];
  assign rs2_val_c = (rs2_c == 5'd0) ? 32'd0 : rf_q[rs2_c];
  assign ld_addr_c = rs1_val_c + imm_i_c;
  assign st_addr_c = rs1_val_c + imm_s_c;

  // Only STATUS is readable; every other load address returns zero.
  assign ld_data_c  = (ld_addr_c == UART_STATUS) ? {31'b0, tx_busy} : 32'd0;
  assign tx_start_c = st_en_c && (st_addr_c == UART_TXDATA);

  always_comb begin
    pc_d      = pc_q + 32'd4;
    wr_en_c   = 1'b0;
    wr_data_c = 32'd0;
    st_en_c   = 1'b0;
    case (opcode_c)
      OP_LUI: begin
        wr_en_c   = 1'b1;
        wr_data_c = imm_u_c;
      end
      OP_OPIMM: begin
        if (funct3_c == F3_ADDI) begin
          wr_en_c   = 1'b1;
          wr_data_c = rs1_val_c + imm_i_c;
        end
      end
      OP_LOAD: begin
        if (funct3_c == F3_WORD) begin
          wr_en_c   = 1'b1;
          wr_data_c = ld_data_c;
        end
      end
      OP_STORE: begin
        if (funct3_c == F3_WORD) st_en_c = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3_c == F3_BNE && rs1_val_c != rs2_val_c) pc_d = pc_q + imm_b_c;
      end
      OP_JAL: begin
        wr_en_c   = 1'b1;
        wr_data_c = pc_q + 32'd4;
        pc_d      = pc_q + imm_j_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (wr_en_c && rd_c != 5'd0) rf_q[rd_c] <= wr_data_c;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk    (clk),
    .reset  (reset),
    .data   (rs2_val_c[7:0]),
    .start  (tx_start_c),
    .busy   (tx_busy),
    .ser_out(ser_out)
  );

endmodule

// File: tb/tb_soc_riscv_uart.sv
// Bench for soc_riscv_uart: decodes ser_out against the expected "Hi" frames under several reset/force scenarios.
module tb_soc_riscv_uart;
  localparam int unsigned CPB = 4;

  logic clk;
  logic reset = 1'b1;
  logic ser_out;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  string       msg   = "Hi";

  typedef struct {
    int          force_at;
    bit          mid_reset;
    logic [31:0] end_pc;
    logic [31:0] end_x3;
  } vec_t;

  vec_t vecs[4];

  soc_riscv_uart #(
    .CLKS_PER_BIT(CPB),
    .ROM_WORDS   (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ser_out(ser_out)
  );

  initial begin
    clk = 1'b1;
    #1;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Line level of an 8N1 frame at clock index idx from its start.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    int slot;
    slot = idx / int'(CPB);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  task automatic hold_reset(input int ncyc);
    reset = 1'b0;
    #1;
    chk("ser_out at reset assert", 32'(ser_out), 32'd1);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk("ser_out during reset", 32'(ser_out), 32'd1);
    end
    reset = 1'b1;
    chk("pc at reset release", dut.pc_q, 32'd0);
  endtask

  task automatic check_frame(input logic [7:0] b, input string tag, input int force_at,
                             input int abort_at, output bit aborted);
    int waited;
    bit forced;
    bit released;
    waited   = 0;
    forced   = 1'b0;
    released = 1'b0;
    aborted  = 1'b0;
    do begin
      @(negedge clk);
      waited++;
    end while (ser_out !== 1'b0 && waited < 400);
    if (ser_out !== 1'b0) begin
      chk({tag, " start bit timeout"}, 32'(ser_out), 32'd0);
      return;
    end
    for (int i = 0; i < 10 * int'(CPB); i++) begin
      if (i > 0) @(negedge clk);
      if (forced && !released) begin
        release dut.instr_c;
        released = 1'b1;
      end
      chk($sformatf("%s bit%0d clk%0d", tag, i / int'(CPB), i % int'(CPB)),
          32'(ser_out), 32'(frame_bit(b, i)));
      if (i == 5 * int'(CPB)) chk({tag, " STATUS mid-frame"}, dut.rf_q[3], 32'd1);
      if (i == abort_at) begin
        aborted = 1'b1;
        return;
      end
      if (force_at >= 0 && i >= force_at && !forced && dut.pc_q == 32'd12) begin
        force dut.instr_c = 32'h0010_A023;  // sw x1, 0(x1) while the frame is in flight
        forced = 1'b1;
      end
    end
    if (forced && !released) release dut.instr_c;
    if (force_at >= 0) chk({tag, " forced store issued"}, 32'(forced), 32'd1);
  endtask

  task automatic check_idle(input int ncyc, input logic [31:0] end_pc, input logic [31:0] end_x3);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk($sformatf("idle ser_out clk%0d", i), 32'(ser_out), 32'd1);
    end
    chk("final pc", dut.pc_q, end_pc);
    chk("STATUS after stop", dut.rf_q[3], end_x3);
  endtask

  initial begin
    bit ab;
    int cut;
    vecs[0] = '{force_at: -1, mid_reset: 1'b0, end_pc: 32'h24, end_x3: 32'd0};
    vecs[1] = '{force_at:  8, mid_reset: 1'b0, end_pc: 32'h24, end_x3: 32'd0};
    vecs[2] = '{force_at: -1, mid_reset: 1'b1, end_pc: 32'h24, end_x3: 32'd0};
    vecs[3] = '{force_at: -1, mid_reset: 1'b1, end_pc: 32'h24, end_x3: 32'd0};

    #1;
    for (int v = 0; v < 4; v++) begin
      hold_reset(2);
      if (vecs[v].mid_reset) begin
        // Cut inside the start bit or the low leading data bits of 'H', so the line is low beforehand.
        cut = int'($urandom_range(4 * CPB - 1, 1));
        check_frame(msg[0], $sformatf("v%0d pre-reset", v), -1, cut, ab);
        chk($sformatf("v%0d frame aborted", v), 32'(ab), 32'd1);
        hold_reset(2);
      end
      for (int c = 0; c < msg.len(); c++) begin
        check_frame(msg[c], $sformatf("v%0d char%0d", v, c), (c == 0) ? vecs[v].force_at : -1, -1, ab);
      end
      check_idle(60, vecs[v].end_pc, vecs[v].end_x3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
